spi_flash_burst_reader: RTL and testbench

Memory-mapped SPI NOR flash read engine; parametrised successor of the single-word mapped flash reader.
- Generalises SCK divider, command mode (READ 0x03 / FAST_READ 0x0B with dummy clocks) and CS_N recovery time.
- Adds multi-word burst reads with a per-word valid strobe, and an abort input.
- Sits between the CPU/cache refill logic and the board flash pins.

---
 rtl/spi_flash_burst_reader_pkg.sv | 22 ++
 rtl/spi_flash_burst_reader_sck_gen.sv | 42 ++++
 rtl/spi_flash_burst_reader.sv | 134 +++++++++++++
 tb/tb_spi_flash_burst_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_burst_reader_pkg.sv
// spi_flash_pkg: shared states, opcodes and byte ordering for the SPI flash burst reader
package spi_flash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_CS_HIGH
    } state_t;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam int         ADDR_BITS     = 24;

    // First byte off the wire lands in bits [7:0] of the delivered word
    function automatic logic [31:0] swizzle(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_burst_reader_sck_gen.sv
// spi_sck_gen: SCK divider with rise/slot-end strobes and a per-phase slot counter
module spi_sck_gen #(
    parameter int CLK_DIV = 2,
    parameter int SW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          slot_last,
    output logic          sck,
    output logic          sample,
    output logic          slot_end,
    output logic [SW-1:0] slot
);

    localparam int            CNW  = $clog2(2 * CLK_DIV);
    localparam logic [CNW-1:0] HALF = CNW'(CLK_DIV - 1);
    localparam logic [CNW-1:0] LAST = CNW'(2 * CLK_DIV - 1);

    logic [CNW-1:0] cnt;

    assign sample   = run && cnt == HALF;
    assign slot_end = run && cnt == LAST;

    // Divider parks at zero with SCK low whenever the engine is not shifting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            sck  <= 1'b0;
            slot <= '0;
        end else if (!run) begin
            cnt  <= '0;
            sck  <= 1'b0;
            slot <= '0;
        end else begin
            cnt  <= slot_end ? '0 : cnt + 1'b1;
            sck  <= sample ? 1'b1 : slot_end ? 1'b0 : sck;
            slot <= slot_end ? (slot_last ? '0 : slot + 1'b1) : slot;
        end
    end

endmodule

// File: rtl/spi_flash_burst_reader.sv
// spi_flash_burst_reader: memory-mapped SPI NOR burst read engine (mode 0)
module spi_flash_burst_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int FAST_READ      = 0,
    parameter int DUMMY_CLOCKS   = 8,
    parameter int MAX_BURST      = 8,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rstrb,
    input  logic [21:0]                    word_address,
    input  logic [$clog2(MAX_BURST+1)-1:0] burst_len,
    input  logic                           abort,
    output logic [31:0]                    rdata,
    output logic                           rvalid,
    output logic                           rbusy,
    output logic                           CLK,
    output logic                           CS_N,
    output logic                           MOSI,
    input  logic                           MISO
);

    localparam int             D   = FAST_READ != 0 ? DUMMY_CLOCKS : 0;
    localparam int             BW  = $clog2(MAX_BURST + 1);
    localparam int             SW  = $clog2(D > 32 ? D : 32);
    localparam int             CW  = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [7:0]     OPC = FAST_READ != 0 ? OPC_FAST_READ : OPC_READ;
    localparam logic [SW-1:0]  LAST_CMD   = SW'(7);
    localparam logic [SW-1:0]  LAST_ADDR  = SW'(ADDR_BITS - 1);
    localparam logic [SW-1:0]  LAST_DUMMY = SW'(D - 1);
    localparam logic [SW-1:0]  LAST_WORD  = SW'(31);
    localparam logic [CW-1:0]  CS_LAST    = CW'(CS_HIGH_CYCLES - 1);
    localparam logic [BW-1:0]  MAXB       = BW'(MAX_BURST);

    state_t         state;
    logic [31:0]    tx;
    logic [31:0]    rx;
    logic [BW-1:0]  words_left;
    logic [CW-1:0]  cs_cnt;
    logic           active;
    logic           run;
    logic           sample;
    logic           slot_end;
    logic           slot_last;
    logic [SW-1:0]  slot;

    assign active    = state != S_IDLE && state != S_CS_HIGH;
    assign run       = active && !abort;
    assign slot_last = slot == (state == S_CMD   ? LAST_CMD  :
                                state == S_ADDR  ? LAST_ADDR :
                                state == S_DUMMY ? LAST_DUMMY : LAST_WORD);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV),
        .SW     (SW)
    ) u_sck (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .slot_last(slot_last),
        .sck      (CLK),
        .sample   (sample),
        .slot_end (slot_end),
        .slot     (slot)
    );

    // Transaction sequencer: command/address shift-out, data shift-in, word delivery, CS recovery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            CS_N       <= 1'b1;
            MOSI       <= 1'b0;
            rbusy      <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            tx         <= '0;
            rx         <= '0;
            words_left <= '0;
            cs_cnt     <= '0;
        end else begin
            rvalid <= 1'b0;
            if (state == S_IDLE) begin
                if (rstrb) begin
                    state      <= S_CMD;
                    CS_N       <= 1'b0;
                    rbusy      <= 1'b1;
                    MOSI       <= OPC[7];
                    tx         <= {OPC[6:0], word_address, 2'b00, 1'b0};
                    words_left <= burst_len == '0 ? BW'(1) : burst_len > MAXB ? MAXB : burst_len;
                end
            end else if (state == S_CS_HIGH) begin
                if (cs_cnt == '0) begin
                    state <= S_IDLE;
                    rbusy <= 1'b0;
                end else begin
                    cs_cnt <= cs_cnt - 1'b1;
                end
            end else if (abort) begin
                state  <= S_CS_HIGH;
                CS_N   <= 1'b1;
                MOSI   <= 1'b0;
                cs_cnt <= CS_LAST;
            end else begin
                if (sample && state == S_DATA) rx <= {rx[30:0], MISO};
                if (slot_end) begin
                    MOSI <= tx[31];
                    tx   <= {tx[30:0], 1'b0};
                end
                if (slot_end && slot_last) begin
                    if (state == S_CMD) begin
                        state <= S_ADDR;
                    end else if (state == S_ADDR) begin
                        state <= D > 0 ? S_DUMMY : S_DATA;
                    end else if (state == S_DUMMY) begin
                        state <= S_DATA;
                    end else begin
                        rdata      <= swizzle(rx);
                        rvalid     <= 1'b1;
                        words_left <= words_left - 1'b1;
                        if (words_left == BW'(1)) begin
                            state  <= S_CS_HIGH;
                            CS_N   <= 1'b1;
                            cs_cnt <= CS_LAST;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// tb_spi_flash_burst_reader: directed checks of READ / FAST_READ bursts, abort, reset and CS recovery
module tb_spi_flash_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] word_address;
    logic [3:0]  burst_len;
    logic        rstrb  [2];
    logic        abort  [2];
    logic        rvalid [2];
    logic        rbusy  [2];
    logic        sck    [2];
    logic        csn    [2];
    logic        mosi   [2];
    logic        miso   [2];
    logic [31:0] rdata  [2];
    logic [31:0] mcap   [2];
    logic [7:0]  mem    [2][64];
    int          rc     [2];
    int          bi     [2];

    int checks = 0;
    int errors = 0;
    int el = 0;
    int at, n, hi;
    logic clk_ok;
    logic [31:0] e2 [4];

    always #5 clk = ~clk;

    spi_flash_burst_reader #(
        .CLK_DIV(2), .FAST_READ(0), .DUMMY_CLOCKS(8), .MAX_BURST(8), .CS_HIGH_CYCLES(4)
    ) dut0 (
        .clk(clk), .reset(reset), .rstrb(rstrb[0]), .word_address(word_address),
        .burst_len(burst_len), .abort(abort[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
        .rbusy(rbusy[0]), .CLK(sck[0]), .CS_N(csn[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_flash_burst_reader #(
        .CLK_DIV(2), .FAST_READ(1), .DUMMY_CLOCKS(8), .MAX_BURST(8), .CS_HIGH_CYCLES(4)
    ) dut1 (
        .clk(clk), .reset(reset), .rstrb(rstrb[1]), .word_address(word_address),
        .burst_len(burst_len), .abort(abort[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
        .rbusy(rbusy[1]), .CLK(sck[1]), .CS_N(csn[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Flash models: capture the first 32 MOSI bits, stream bytes MSB first after cmd/addr/dummy
    for (genvar g = 0; g < 2; g++) begin : flash
        localparam int DL = g == 1 ? 8 : 0;
        always @(posedge csn[g] or posedge sck[g] or negedge sck[g]) begin
            if (csn[g]) begin
                rc[g] = 0;
            end else if (sck[g]) begin
                mcap[g] = rc[g] == 0 ? {31'b0, mosi[g]} : rc[g] < 32 ? {mcap[g][30:0], mosi[g]} : mcap[g];
                rc[g]++;
            end else if (rc[g] >= 32 + DL) begin
                bi[g]   = rc[g] - 32 - DL;
                miso[g] = mem[g][(bi[g] / 8) % 64][7 - (bi[g] % 8)];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        el++;
    endtask

    task automatic start(input int g, input logic [21:0] a, input logic [3:0] bl);
        word_address = a;
        burst_len    = bl;
        rstrb[g]     = 1'b1;
        tick();
        rstrb[g]     = 1'b0;
        el           = 0;
    endtask

    task automatic wait_rv(input int g, output int t);
        t = -1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (rvalid[g]) begin
                t = el;
                break;
            end
        end
    endtask

    task automatic run_idle(input int g, output int pulses);
        pulses = 0;
        for (int k = 0; k < 5000 && rbusy[g]; k++) begin
            tick();
            if (rvalid[g]) pulses++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        rstrb[0] = 1'b0; rstrb[1] = 1'b0;
        abort[0] = 1'b0; abort[1] = 1'b0;
        word_address = '0;
        burst_len = '0;
        for (int i = 0; i < 64; i++) begin
            mem[0][i] = 8'(i);
            mem[1][i] = 8'(i);
        end
        mem[0][0] = 8'hDE; mem[0][1] = 8'hAD; mem[0][2] = 8'hBE; mem[0][3] = 8'hEF;
        e2[0] = 32'h03020100; e2[1] = 32'h07060504; e2[2] = 32'h0B0A0908; e2[3] = 32'h0F0E0D0C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", csn[0], 1);
        chk("rst_clk", sck[0], 0);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_rbusy", rbusy[0], 0);
        chk("rst_rvalid", rvalid[0], 0);
        chk("rst_rdata", rdata[0], 0);
        reset = 1'b1;
        tick(); tick();

        start(0, 22'h000010, 4'd1);
        chk("t1_csn_low", csn[0], 0);
        chk("t1_rbusy", rbusy[0], 1);
        wait_rv(0, at);
        chk("t1_rv_time", at, 256);
        chk("t1_rdata", rdata[0], 32'hEFBEADDE);
        chk("t1_csn_high", csn[0], 1);
        chk("t1_clk_low", sck[0], 0);
        chk("t1_mosi_cmd_addr", mcap[0], 32'h03000040);
        repeat (3) tick();
        chk("t1_rvalid_pulse", rvalid[0], 0);
        chk("t1_rbusy_259", rbusy[0], 1);
        tick();
        chk("t1_rbusy_260", rbusy[0], 0);

        start(1, 22'h002000, 4'd4);
        for (int k = 0; k < 4; k++) begin
            wait_rv(1, at);
            chk($sformatf("t2_rv_time_%0d", k), at, (40 + 32 * (k + 1)) * 4);
            chk($sformatf("t2_rdata_%0d", k), rdata[1], e2[k]);
        end
        chk("t2_mosi_cmd_addr", mcap[1], 32'h0B008000);
        run_idle(1, n);
        chk("t2_extra_words", n, 0);
        chk("t2_idle", rbusy[1], 0);

        start(0, 22'h0, 4'd0);
        run_idle(0, n);
        chk("t3_len0_words", n, 1);
        chk("t3_len0_rdata", rdata[0], 32'hEFBEADDE);
        start(0, 22'h0, 4'd15);
        run_idle(0, n);
        chk("t3_len15_words", n, 8);
        chk("t3_len15_rdata", rdata[0], 32'h1F1E1D1C);

        start(0, 22'h3FFFFF, 4'd2);
        repeat (61) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("t4a_csn", csn[0], 1);
        chk("t4a_clk", sck[0], 0);
        chk("t4a_mosi", mosi[0], 0);
        chk("t4a_rvalid", rvalid[0], 0);
        chk("t4a_rdata", rdata[0], 32'h1F1E1D1C);
        repeat (3) tick();
        chk("t4a_rbusy_hold", rbusy[0], 1);
        tick();
        chk("t4a_rbusy_drop", rbusy[0], 0);

        start(0, 22'h0, 4'd2);
        repeat (255) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("t4b_rvalid", rvalid[0], 0);
        chk("t4b_csn", csn[0], 1);
        chk("t4b_rdata", rdata[0], 32'h1F1E1D1C);
        repeat (4) tick();
        chk("t4b_rbusy_drop", rbusy[0], 0);

        start(0, 22'h000010, 4'd1);
        repeat (19) tick();
        rstrb[0] = 1'b1;
        tick();
        rstrb[0] = 1'b0;
        repeat (129) tick();
        rstrb[0] = 1'b1;
        tick();
        rstrb[0] = 1'b0;
        wait_rv(0, at);
        chk("t5_rv_time", at, 256);
        chk("t5_mosi_cmd_addr", mcap[0], 32'h03000040);
        repeat (4) tick();
        chk("t5_idle", rbusy[0], 0);
        repeat (3) tick();
        chk("t5_no_queued_rbusy", rbusy[0], 0);
        chk("t5_no_queued_csn", csn[0], 1);

        start(0, 22'h000010, 4'd1);
        repeat (199) tick();
        reset = 1'b0;
        #1;
        chk("t5r_csn", csn[0], 1);
        chk("t5r_clk", sck[0], 0);
        chk("t5r_rbusy", rbusy[0], 0);
        chk("t5r_rvalid", rvalid[0], 0);
        chk("t5r_rdata", rdata[0], 0);
        tick();
        reset = 1'b1;
        tick();
        start(0, 22'h000010, 4'd1);
        wait_rv(0, at);
        chk("t5r_rv_time", at, 256);
        chk("t5r_rdata_after", rdata[0], 32'hEFBEADDE);
        chk("t5r_mosi_cmd_addr", mcap[0], 32'h03000040);
        repeat (4) tick();

        word_address = 22'h000010;
        burst_len = 4'd1;
        rstrb[0] = 1'b1;
        tick();
        el = 0;
        wait_rv(0, at);
        chk("t6_rv1_time", at, 256);
        hi = 0;
        clk_ok = 1'b1;
        for (int k = 0; k < 20 && csn[0]; k++) begin
            if (sck[0] !== 1'b0) clk_ok = 1'b0;
            hi++;
            tick();
        end
        chk("t6_csn_high_cycles", hi, 5);
        chk("t6_clk_low_while_csn_high", clk_ok, 1);
        wait_rv(0, at);
        chk("t6_rv2_time", at, 517);
        rstrb[0] = 1'b0;
        run_idle(0, n);
        chk("t6_idle", rbusy[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
